// File: rtl/prefetch_issue_queue.sv
// Prefetch issue queue: block-aligns up to three prefetch candidates per cycle and drops duplicates.
// Survivors go into a FIFO that issues on a valid/ready handshake, with saturating drop counters.
module prefetch_issue_queue #(
  parameter int ADDR_SIZE       = 64,
  parameter int LOG2_BLOCK_SIZE = 6,
  parameter int QUEUE_DEPTH     = 8,
  parameter int FILTER_ENTRIES  = 4
) (
  input  logic                               clk,
  input  logic                               rst,
  input  logic [ADDR_SIZE-1:0]               pref_addr1_i,
  input  logic                               pref_valid1_i,
  input  logic [ADDR_SIZE-1:0]               pref_addr2_i,
  input  logic                               pref_valid2_i,
  input  logic [ADDR_SIZE-1:0]               pref_addr3_i,
  input  logic                               pref_valid3_i,
  input  logic                               flush_i,
  output logic                               req_valid_o,
  output logic [ADDR_SIZE-1:0]               req_addr_o,
  input  logic                               req_ready_i,
  output logic [$clog2(QUEUE_DEPTH):0]       occupancy_o,
  output logic [15:0]                        drop_full_o,
  output logic [15:0]                        drop_dup_o
);

  localparam int PTR_W  = $clog2(QUEUE_DEPTH);
  localparam int OCC_W  = PTR_W + 1;
  localparam int FPTR_W = (FILTER_ENTRIES > 1) ? $clog2(FILTER_ENTRIES) : 1;
  localparam logic [ADDR_SIZE-1:0] BLK_MASK = {ADDR_SIZE{1'b1}} << LOG2_BLOCK_SIZE;

  logic [ADDR_SIZE-1:0] r_fifo [QUEUE_DEPTH];
  logic [PTR_W-1:0]     r_wr_ptr;
  logic [PTR_W-1:0]     r_rd_ptr;
  logic [OCC_W-1:0]     r_occ;
  logic [ADDR_SIZE-1:0] r_filt [FILTER_ENTRIES];
  logic [FILTER_ENTRIES-1:0] r_filt_vld;
  logic [FPTR_W-1:0]    r_filt_ptr;
  logic [15:0]          r_drop_full;
  logic [15:0]          r_drop_dup;

  logic [ADDR_SIZE-1:0] w_blk [3];
  logic [2:0]           w_cand_vld;
  logic [2:0]           w_dup;
  logic [2:0]           w_push;
  logic [PTR_W-1:0]     w_slot [3];
  logic [PTR_W-1:0]     w_offs [QUEUE_DEPTH];
  logic [QUEUE_DEPTH-1:0] w_ent_vld;
  logic [OCC_W-1:0]     w_free;
  logic [OCC_W-1:0]     w_npush;
  logic [1:0]           w_nfull;
  logic [1:0]           w_ndup;
  logic                 w_pop;
  logic [16:0]          w_full_sum;
  logic [16:0]          w_dup_sum;

  assign req_valid_o = (r_occ != '0);
  assign req_addr_o  = r_fifo[r_rd_ptr];
  assign occupancy_o = r_occ;
  assign drop_full_o = r_drop_full;
  assign drop_dup_o  = r_drop_dup;
  assign w_pop       = req_valid_o && req_ready_i;

  always_comb begin
    w_blk[0]   = pref_addr1_i & BLK_MASK;
    w_blk[1]   = pref_addr2_i & BLK_MASK;
    w_blk[2]   = pref_addr3_i & BLK_MASK;
    w_cand_vld = {pref_valid3_i, pref_valid2_i, pref_valid1_i} & {3{~flush_i}};
    w_ent_vld  = '0;
    w_dup      = '0;
    w_push     = '0;
    w_npush    = '0;
    w_nfull    = '0;
    w_ndup     = '0;
    w_free     = OCC_W'(QUEUE_DEPTH) - r_occ;

    // Entry i is live when its distance from the head is below the occupancy.
    for (int i = 0; i < QUEUE_DEPTH; i++) begin
      w_offs[i]    = PTR_W'(i) - r_rd_ptr;
      w_ent_vld[i] = ({1'b0, w_offs[i]} < r_occ);
    end

    for (int k = 0; k < 3; k++) begin
      for (int i = 0; i < QUEUE_DEPTH; i++)
        if (w_ent_vld[i] && (r_fifo[i] == w_blk[k])) w_dup[k] = 1'b1;
      for (int f = 0; f < FILTER_ENTRIES; f++)
        if (r_filt_vld[f] && (r_filt[f] == w_blk[k])) w_dup[k] = 1'b1;
      for (int j = 0; j < 3; j++)
        if ((j < k) && w_cand_vld[j] && (w_blk[j] == w_blk[k])) w_dup[k] = 1'b1;
      w_dup[k] = w_dup[k] & w_cand_vld[k];
    end

    // Slots are allocated in priority order; a same-cycle pop does not free space.
    for (int k = 0; k < 3; k++) begin
      w_slot[k] = r_wr_ptr + w_npush[PTR_W-1:0];
      if (w_dup[k]) begin
        w_ndup = w_ndup + 2'd1;
      end else if (w_cand_vld[k]) begin
        if (w_npush < w_free) begin
          w_push[k] = 1'b1;
          w_npush   = w_npush + OCC_W'(1);
        end else begin
          w_nfull = w_nfull + 2'd1;
        end
      end
    end

    w_full_sum = {1'b0, r_drop_full} + 17'(w_nfull);
    w_dup_sum  = {1'b0, r_drop_dup} + 17'(w_ndup);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < QUEUE_DEPTH; i++) r_fifo[i] <= '0;
      for (int f = 0; f < FILTER_ENTRIES; f++) r_filt[f] <= '0;
      r_wr_ptr    <= '0;
      r_rd_ptr    <= '0;
      r_occ       <= '0;
      r_filt_vld  <= '0;
      r_filt_ptr  <= '0;
      r_drop_full <= '0;
      r_drop_dup  <= '0;
    end else begin
      r_drop_full <= w_full_sum[16] ? 16'hFFFF : w_full_sum[15:0];
      r_drop_dup  <= w_dup_sum[16] ? 16'hFFFF : w_dup_sum[15:0];
      if (flush_i) begin
        r_wr_ptr   <= '0;
        r_rd_ptr   <= '0;
        r_occ      <= '0;
        r_filt_vld <= '0;
        r_filt_ptr <= '0;
      end else begin
        for (int k = 0; k < 3; k++)
          if (w_push[k]) r_fifo[w_slot[k]] <= w_blk[k];
        r_wr_ptr <= r_wr_ptr + w_npush[PTR_W-1:0];
        r_occ    <= r_occ + w_npush - OCC_W'(w_pop);
        if (w_pop) begin
          r_rd_ptr               <= r_rd_ptr + PTR_W'(1);
          r_filt[r_filt_ptr]     <= req_addr_o;
          r_filt_vld[r_filt_ptr] <= 1'b1;
          r_filt_ptr <= (r_filt_ptr == FPTR_W'(FILTER_ENTRIES - 1)) ? '0 : r_filt_ptr + FPTR_W'(1);
        end
      end
    end
  end

endmodule

// File: tb/tb_prefetch_issue_queue.sv
// Directed table-driven bench for prefetch_issue_queue, plus hand sequences for
// counter saturation and asynchronous reset mid-operation.
module tb_prefetch_issue_queue;

  logic        clk = 1'b0;
  logic        rst;
  logic [63:0] pref_addr1_i, pref_addr2_i, pref_addr3_i;
  logic        pref_valid1_i, pref_valid2_i, pref_valid3_i;
  logic        flush_i;
  logic        req_valid_o;
  logic [63:0] req_addr_o;
  logic        req_ready_i;
  logic [3:0]  occupancy_o;
  logic [15:0] drop_full_o;
  logic [15:0] drop_dup_o;

  int n_chk = 0;
  int n_err = 0;

  prefetch_issue_queue dut (
    .clk(clk), .rst(rst),
    .pref_addr1_i(pref_addr1_i), .pref_valid1_i(pref_valid1_i),
    .pref_addr2_i(pref_addr2_i), .pref_valid2_i(pref_valid2_i),
    .pref_addr3_i(pref_addr3_i), .pref_valid3_i(pref_valid3_i),
    .flush_i(flush_i),
    .req_valid_o(req_valid_o), .req_addr_o(req_addr_o), .req_ready_i(req_ready_i),
    .occupancy_o(occupancy_o), .drop_full_o(drop_full_o), .drop_dup_o(drop_dup_o)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [2:0]  v;
    logic [63:0] a1, a2, a3;
    logic        rdy, fl;
    logic        e_vld;
    logic [63:0] e_addr;
    logic [3:0]  e_occ;
    logic [15:0] e_df, e_dd;
  } vec_t;

  vec_t vecs [21];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic drive(input logic [2:0] v, input logic [63:0] a1, input logic [63:0] a2,
                       input logic [63:0] a3, input logic rdy, input logic fl);
    pref_valid1_i = v[0]; pref_valid2_i = v[1]; pref_valid3_i = v[2];
    pref_addr1_i = a1; pref_addr2_i = a2; pref_addr3_i = a3;
    req_ready_i = rdy; flush_i = fl;
    @(posedge clk);
    #1;
  endtask

  initial begin
    // v    a1          a2          a3          rdy fl   vld addr        occ df  dd
    vecs[0]  = '{3'b111, 64'h1040, 64'h1080, 64'h10C0, 1'b1, 1'b0, 1'b1, 64'h1040, 4'd3, 16'd0, 16'd0};
    vecs[1]  = '{3'b000, 64'h0,    64'h0,    64'h0,    1'b1, 1'b0, 1'b1, 64'h1080, 4'd2, 16'd0, 16'd0};
    vecs[2]  = '{3'b000, 64'h0,    64'h0,    64'h0,    1'b1, 1'b0, 1'b1, 64'h10C0, 4'd1, 16'd0, 16'd0};
    vecs[3]  = '{3'b000, 64'h0,    64'h0,    64'h0,    1'b1, 1'b0, 1'b0, 64'h0,    4'd0, 16'd0, 16'd0};
    vecs[4]  = '{3'b111, 64'h2000, 64'h2020, 64'h2000, 1'b0, 1'b0, 1'b1, 64'h2000, 4'd1, 16'd0, 16'd2};
    vecs[5]  = '{3'b000, 64'h0,    64'h0,    64'h0,    1'b1, 1'b0, 1'b0, 64'h0,    4'd0, 16'd0, 16'd2};
    vecs[6]  = '{3'b001, 64'h2008, 64'h0,    64'h0,    1'b1, 1'b0, 1'b0, 64'h0,    4'd0, 16'd0, 16'd3};
    vecs[7]  = '{3'b111, 64'h3000, 64'h3040, 64'h3080, 1'b0, 1'b0, 1'b1, 64'h3000, 4'd3, 16'd0, 16'd3};
    vecs[8]  = '{3'b111, 64'h30C0, 64'h3100, 64'h3140, 1'b0, 1'b0, 1'b1, 64'h3000, 4'd6, 16'd0, 16'd3};
    vecs[9]  = '{3'b111, 64'h3180, 64'h31C0, 64'h3200, 1'b0, 1'b0, 1'b1, 64'h3000, 4'd8, 16'd1, 16'd3};
    vecs[10] = '{3'b111, 64'h3240, 64'h3280, 64'h32C0, 1'b0, 1'b0, 1'b1, 64'h3000, 4'd8, 16'd4, 16'd3};
    vecs[11] = '{3'b111, 64'h3300, 64'h3340, 64'h3380, 1'b1, 1'b0, 1'b1, 64'h3040, 4'd7, 16'd7, 16'd3};
    vecs[12] = '{3'b111, 64'h3300, 64'h3340, 64'h3380, 1'b0, 1'b0, 1'b1, 64'h3040, 4'd8, 16'd9, 16'd3};
    // candidate equal to the head popping this cycle is a duplicate
    vecs[13] = '{3'b001, 64'h3040, 64'h0,    64'h0,    1'b1, 1'b0, 1'b1, 64'h3080, 4'd7, 16'd9, 16'd4};
    // 1040 was evicted from the filter by round-robin; 10C0 is still resident
    vecs[14] = '{3'b011, 64'h1040, 64'h10C0, 64'h0,    1'b1, 1'b0, 1'b1, 64'h30C0, 4'd7, 16'd9, 16'd5};
    vecs[15] = '{3'b111, 64'h4000, 64'h4040, 64'h4080, 1'b0, 1'b1, 1'b0, 64'h0,    4'd0, 16'd9, 16'd5};
    vecs[16] = '{3'b111, 64'h3000, 64'h1040, 64'h2000, 1'b0, 1'b0, 1'b1, 64'h3000, 4'd3, 16'd9, 16'd5};
    vecs[17] = '{3'b000, 64'h0,    64'h0,    64'h0,    1'b1, 1'b0, 1'b1, 64'h1040, 4'd2, 16'd9, 16'd5};
    vecs[18] = '{3'b000, 64'h0,    64'h0,    64'h0,    1'b1, 1'b1, 1'b0, 64'h0,    4'd0, 16'd9, 16'd5};
    vecs[19] = '{3'b011, 64'h1040, 64'h3000, 64'h0,    1'b0, 1'b0, 1'b1, 64'h1040, 4'd2, 16'd9, 16'd5};
    vecs[20] = '{3'b111, 64'h1040, 64'h1041, 64'h107F, 1'b0, 1'b0, 1'b1, 64'h1040, 4'd2, 16'd9, 16'd8};

    rst = 1'b1;
    pref_addr1_i = '0; pref_addr2_i = '0; pref_addr3_i = '0;
    pref_valid1_i = 1'b0; pref_valid2_i = 1'b0; pref_valid3_i = 1'b0;
    flush_i = 1'b0; req_ready_i = 1'b0;
    #12;
    chk("reset_valid", 64'(req_valid_o), 64'h0);
    chk("reset_addr", req_addr_o, 64'h0);
    chk("reset_occ", 64'(occupancy_o), 64'h0);
    chk("reset_dfull", 64'(drop_full_o), 64'h0);
    chk("reset_ddup", 64'(drop_dup_o), 64'h0);
    @(negedge clk);
    rst = 1'b0;

    for (int i = 0; i < 21; i++) begin
      drive(vecs[i].v, vecs[i].a1, vecs[i].a2, vecs[i].a3, vecs[i].rdy, vecs[i].fl);
      chk($sformatf("v%0d_valid", i), 64'(req_valid_o), 64'(vecs[i].e_vld));
      chk($sformatf("v%0d_occ", i), 64'(occupancy_o), 64'(vecs[i].e_occ));
      chk($sformatf("v%0d_dfull", i), 64'(drop_full_o), 64'(vecs[i].e_df));
      chk($sformatf("v%0d_ddup", i), 64'(drop_dup_o), 64'(vecs[i].e_dd));
      if (vecs[i].e_vld)
        chk($sformatf("v%0d_addr", i), req_addr_o, vecs[i].e_addr);
    end

    // Saturation: drop_dup is 8; each cycle adds 3 while the head 1040 is held.
    for (int c = 0; c < 21842; c++)
      drive(3'b111, 64'h1040, 64'h1040, 64'h1040, 1'b0, 1'b0);
    chk("sat_below", 64'(drop_dup_o), 64'hFFFE);
    drive(3'b111, 64'h1040, 64'h1040, 64'h1040, 1'b0, 1'b0);
    chk("sat_hit", 64'(drop_dup_o), 64'hFFFF);
    drive(3'b111, 64'h1040, 64'h1040, 64'h1040, 1'b0, 1'b0);
    chk("sat_hold", 64'(drop_dup_o), 64'hFFFF);
    chk("sat_occ", 64'(occupancy_o), 64'h2);
    chk("sat_head", req_addr_o, 64'h1040);

    drive(3'b111, 64'h5000, 64'h5040, 64'h5080, 1'b0, 1'b0);
    chk("pre_rst_occ", 64'(occupancy_o), 64'h5);
    drive(3'b000, 64'h0, 64'h0, 64'h0, 1'b0, 1'b0);
    @(negedge clk);
    rst = 1'b1;
    #1;
    chk("midrst_valid", 64'(req_valid_o), 64'h0);
    chk("midrst_occ", 64'(occupancy_o), 64'h0);
    chk("midrst_addr", req_addr_o, 64'h0);
    chk("midrst_dfull", 64'(drop_full_o), 64'h0);
    chk("midrst_ddup", 64'(drop_dup_o), 64'h0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
